mem_arbiter: RTL

- Shares the single-port instruction/data memory between two requesters: the CPU (driven by the control sequencer's mem_rd/mem_wr) and a DMA/loader port used for program load and memory dump.
- Sits between both requesters and the memory model.
- Owner-based FSM, one transfer per cycle, bounded-burst fairness.
- Routes 1-cycle-latency read data back to the requester that issued the read.

---
 rtl/mem_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the CPU and a DMA/loader port.
// Owner-based FSM, one transfer per cycle, bounded bursts, tagged 1-cycle read return.
module mem_arbiter #(
  parameter int AWIDTH    = 5,
  parameter int DWIDTH    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [AWIDTH-1:0] cpu_addr,
  input  logic [DWIDTH-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DWIDTH-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_wr,
  input  logic [AWIDTH-1:0] dma_addr,
  input  logic [DWIDTH-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DWIDTH-1:0] dma_rdata,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  // Handshake: a requester holds req/wr/addr/wdata stable until gnt; a transfer
  // occurs in every cycle where req && gnt, and a read returns rvalid/rdata
  // exactly one cycle later on the same requester's port.

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_OWN_CPU = 2'd1,
    S_OWN_DMA = 2'd2
  } state_t;

  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_t          r_state;
  state_t          w_next_state;
  logic [CW-1:0]   r_burst_cnt;
  logic [CW-1:0]   w_next_cnt;
  logic            r_tag_cpu;
  logic            r_tag_dma;

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      r_state     <= S_IDLE;
      r_burst_cnt <= '0;
      r_tag_cpu   <= 1'b0;
      r_tag_dma   <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_burst_cnt <= w_next_cnt;
      r_tag_cpu   <= cpu_gnt & ~cpu_wr;
      r_tag_dma   <= dma_gnt & ~dma_wr;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_burst_cnt;
    cpu_gnt      = 1'b0;
    dma_gnt      = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_next_cnt = '0;
        if (cpu_req)      w_next_state = S_OWN_CPU;
        else if (dma_req) w_next_state = S_OWN_DMA;
      end
      S_OWN_CPU: begin
        cpu_gnt = cpu_req;
        if (cpu_req) begin
          mem_addr  = cpu_addr;
          mem_wdata = cpu_wdata;
          mem_rd    = ~cpu_wr;
          mem_wr    = cpu_wr;
          if (r_burst_cnt != CNT_MAX) w_next_cnt = r_burst_cnt + CNT_ONE;
          // Burst exhausted while DMA waits: hand over with no idle cycle.
          if (dma_req && (r_burst_cnt == CNT_MAX)) begin
            w_next_state = S_OWN_DMA;
            w_next_cnt   = '0;
          end
        end else begin
          w_next_cnt   = '0;
          w_next_state = dma_req ? S_OWN_DMA : S_IDLE;
        end
      end
      S_OWN_DMA: begin
        dma_gnt = dma_req;
        if (dma_req) begin
          mem_addr  = dma_addr;
          mem_wdata = dma_wdata;
          mem_rd    = ~dma_wr;
          mem_wr    = dma_wr;
          if (r_burst_cnt != CNT_MAX) w_next_cnt = r_burst_cnt + CNT_ONE;
          if (cpu_req && (r_burst_cnt == CNT_MAX)) begin
            w_next_state = S_OWN_CPU;
            w_next_cnt   = '0;
          end
        end else begin
          w_next_cnt   = '0;
          w_next_state = cpu_req ? S_OWN_CPU : S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_cnt   = '0;
      end
    endcase
  end

  // Read return follows the tag, not the state, so it survives an ownership change.
  assign cpu_rvalid = r_tag_cpu;
  assign cpu_rdata  = r_tag_cpu ? mem_rdata : '0;
  assign dma_rvalid = r_tag_dma;
  assign dma_rdata  = r_tag_dma ? mem_rdata : '0;
  assign busy       = (r_state != S_IDLE);
  assign dbg_state  = r_state;

endmodule
